// File: rtl/inst_sram_bridge_pkg.sv
// Shared constants and types for the instruction-fetch SRAM-to-bus bridge.
package inst_sram_bridge_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    // Width of the WAIT-phase timeout counter.
    localparam int TIMER_W = 8;

    // Word handed to the CPU when a fetch fails; decodes as a NOP.
    localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } bridge_state_e;

    // Clear the byte offset so the bus only ever sees word addresses.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    // Any nonzero byte offset is an illegal instruction fetch.
    function automatic logic is_misaligned(input logic [1:0] lo);
        return lo != 2'b00;
    endfunction

endpackage

// File: rtl/inst_sram_bridge_timer.sv
// Cycle counter bounding how long the bridge waits for a bus response.
module bridge_timer
    import inst_sram_bridge_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Count value seen during the last permitted waiting cycle.
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Clear wins over enable so a fresh wait always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/inst_sram_bridge.sv
// Bridges the CPU's synchronous instruction-SRAM port onto a valid/ready bus,
// with a one-entry hit buffer, misalignment trapping and a response timeout.
//
// Handshakes: a request transfers on a rising edge where bus_req_valid and
// bus_req_ready are both 1; once raised, valid stays high and addr/wen/wdata
// stay stable until that edge. A response is a single-cycle bus_rsp_valid
// pulse, accepted only while the bridge is in WAIT; at any other time it is
// ignored.
module inst_sram_bridge
    import inst_sram_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_sram_en,
    input  logic              inst_sram_wen,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    input  logic [DATA_W-1:0] inst_sram_write_data,
    output logic [DATA_W-1:0] inst_sram_read_data,
    output logic              stall_req,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_wen,
    output logic [DATA_W-1:0] bus_req_wdata,
    input  logic              bus_rsp_valid,
    input  logic [DATA_W-1:0] bus_rsp_data,
    output logic              fetch_err,
    output bridge_state_e     dbg_state_o
);

    bridge_state_e     state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_wen_q, req_wen_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] hit_data_q, hit_data_d;
    logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
    logic              tag_valid_q, tag_valid_d;
    logic              fetch_err_q, fetch_err_d;

    logic is_hit;
    logic is_mis;
    logic timer_clear;
    logic timer_expired;

    // A hit is a read of the last completed read address while the tag is live.
    assign is_hit = inst_sram_en && !inst_sram_wen && tag_valid_q
                    && (inst_sram_addr == tag_addr_q);
    assign is_mis = is_misaligned(inst_sram_addr[1:0]);

    bridge_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (state_q == ST_WAIT),
        .expired (timer_expired)
    );

    // Next-state logic plus the stall and timer-clear outputs of the FSM.
    always_comb begin
        state_d     = state_q;
        stall_req   = 1'b0;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_sram_en && !is_hit) begin
                    stall_req = 1'b1;
                    state_d   = is_mis ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall_req = 1'b1;
                if (bus_req_ready) begin
                    state_d     = ST_WAIT;
                    timer_clear = 1'b1;
                end
            end
            ST_WAIT: begin
                stall_req = 1'b1;
                if (bus_rsp_valid || timer_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next-state: request latch, read word, hit buffer, tag, error pulse.
    always_comb begin
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        rdata_d     = rdata_q;
        hit_data_d  = hit_data_q;
        tag_addr_d  = tag_addr_q;
        tag_valid_d = tag_valid_q;
        fetch_err_d = 1'b0;

        if (state_q == ST_IDLE && inst_sram_en) begin
            // Any write that targets the buffered address makes it stale.
            if (inst_sram_wen && inst_sram_addr == tag_addr_q) begin
                tag_valid_d = 1'b0;
            end
            if (is_hit) begin
                rdata_d = hit_data_q;
            end else if (is_mis) begin
                rdata_d     = NOP_WORD;
                fetch_err_d = 1'b1;
            end else begin
                req_addr_d  = word_align(inst_sram_addr);
                req_wen_d   = inst_sram_wen;
                req_wdata_d = inst_sram_write_data;
            end
        end

        if (state_q == ST_WAIT) begin
            // A response in the expiring cycle still counts as a success.
            if (bus_rsp_valid) begin
                if (!req_wen_q) begin
                    rdata_d     = bus_rsp_data;
                    hit_data_d  = bus_rsp_data;
                    tag_addr_d  = req_addr_q;
                    tag_valid_d = 1'b1;
                end
            end else if (timer_expired) begin
                rdata_d     = NOP_WORD;
                tag_valid_d = 1'b0;
                fetch_err_d = 1'b1;
            end
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            rdata_q     <= NOP_WORD;
            hit_data_q  <= '0;
            tag_addr_q  <= '0;
            tag_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
            hit_data_q  <= hit_data_d;
            tag_addr_q  <= tag_addr_d;
            tag_valid_q <= tag_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign bus_req_valid       = (state_q == ST_REQ);
    assign bus_req_addr        = req_addr_q;
    assign bus_req_wen         = req_wen_q;
    assign bus_req_wdata       = req_wdata_q;
    assign inst_sram_read_data = rdata_q;
    assign fetch_err           = fetch_err_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_inst_sram_bridge.sv
// Self-checking bench for inst_sram_bridge: directed scenarios, then random
// fetch/write traffic compared against a transaction-level model.
module tb_inst_sram_bridge;
    import inst_sram_bridge_pkg::*;

    localparam int TMO = 4;

    logic          clk;
    logic          rst;
    logic          inst_sram_en;
    logic          inst_sram_wen;
    logic [31:0]   inst_sram_addr;
    logic [31:0]   inst_sram_write_data;
    logic [31:0]   inst_sram_read_data;
    logic          stall_req;
    logic          bus_req_valid;
    logic          bus_req_ready;
    logic [31:0]   bus_req_addr;
    logic          bus_req_wen;
    logic [31:0]   bus_req_wdata;
    logic          bus_rsp_valid;
    logic [31:0]   bus_rsp_data;
    logic          fetch_err;
    bridge_state_e dbg_state;

    inst_sram_bridge #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .inst_sram_en         (inst_sram_en),
        .inst_sram_wen        (inst_sram_wen),
        .inst_sram_addr       (inst_sram_addr),
        .inst_sram_write_data (inst_sram_write_data),
        .inst_sram_read_data  (inst_sram_read_data),
        .stall_req            (stall_req),
        .bus_req_valid        (bus_req_valid),
        .bus_req_ready        (bus_req_ready),
        .bus_req_addr         (bus_req_addr),
        .bus_req_wen          (bus_req_wen),
        .bus_req_wdata        (bus_req_wdata),
        .bus_rsp_valid        (bus_rsp_valid),
        .bus_rsp_data         (bus_rsp_data),
        .fetch_err            (fetch_err),
        .dbg_state_o          (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    // Reference model: one buffered word plus the word the CPU currently sees.
    logic        m_tag_v;
    logic [31:0] m_tag_a;
    logic [31:0] m_word;
    logic [31:0] m_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tag_v = 1'b0;
        m_tag_a = 32'h0;
        m_word  = 32'h0;
        m_rdata = 32'h0;
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, "_valid"}, bus_req_valid, 0);
        check({tag, "_wen"}, bus_req_wen, 0);
        check({tag, "_stall"}, stall_req, 0);
        check({tag, "_err"}, fetch_err, 0);
        check({tag, "_addr"}, bus_req_addr, 0);
        check({tag, "_wdata"}, bus_req_wdata, 0);
        check({tag, "_rdata"}, inst_sram_read_data, 0);
    endtask

    // ---------------- driver tasks ----------------
    // Cycles with the CPU port disabled and noise on the bus inputs.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            inst_sram_en         = 1'b0;
            inst_sram_wen        = 1'($urandom_range(0, 1));
            inst_sram_addr       = $urandom;
            inst_sram_write_data = $urandom;
            bus_req_ready        = 1'($urandom_range(0, 1));
            bus_rsp_valid        = 1'($urandom_range(0, 1));
            bus_rsp_data         = $urandom;
            #1;
            check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
            check("idle_stall", stall_req, 0);
            check("idle_valid", bus_req_valid, 0);
            check("idle_err", fetch_err, 0);
            check("idle_rdata", inst_sram_read_data, m_rdata);
        end
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
    endtask

    // One CPU access. The bus grants ready from the (ready_dly+1)-th cycle after
    // presentation and returns rsp_word rsp_dly cycles into the wait (negative
    // means never). Responses that come too late stay asserted to prove they
    // are ignored.
    task automatic access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ready_dly, input int rsp_dly, input logic [31:0] rsp_word,
                          output int stalls);
        bit            hit;
        bit            mis;
        bit            tmo;
        int            a;
        int            done;
        logic [31:0]   rd;
        bridge_state_e exp_st;

        hit    = !wen && m_tag_v && (addr == m_tag_a);
        mis    = (addr[1:0] != 2'b00);
        stalls = 0;

        @(negedge clk);
        inst_sram_en         = 1'b1;
        inst_sram_wen        = wen;
        inst_sram_addr       = addr;
        inst_sram_write_data = wdata;
        bus_req_ready        = 1'b0;
        bus_rsp_valid        = 1'b0;
        #1;
        check("present_state", 32'(dbg_state), 32'(ST_IDLE));
        check("present_stall", stall_req, 32'(!hit));
        check("present_valid", bus_req_valid, 0);
        if (stall_req) stalls++;

        if (wen && addr == m_tag_a) m_tag_v = 1'b0;

        if (hit) begin
            m_rdata = m_word;
            exp_q.push_back(m_rdata);
            @(negedge clk);
            inst_sram_en = 1'b0;
            #1;
            rd = exp_q.pop_front();
            check("hit_rdata", inst_sram_read_data, rd);
            check("hit_stall", stall_req, 0);
            check("hit_valid", bus_req_valid, 0);
            check("hit_state", 32'(dbg_state), 32'(ST_IDLE));
            return;
        end

        if (mis) begin
            m_rdata = NOP_WORD;
            exp_q.push_back(m_rdata);
            @(negedge clk);
            inst_sram_en = 1'b0;
            #1;
            rd = exp_q.pop_front();
            check("mis_state", 32'(dbg_state), 32'(ST_DONE));
            check("mis_err", fetch_err, 1);
            check("mis_rdata", inst_sram_read_data, rd);
            check("mis_valid", bus_req_valid, 0);
            check("mis_stall", stall_req, 0);
            @(negedge clk);
            #1;
            check("mis_err_clear", fetch_err, 0);
            check("mis_after_state", 32'(dbg_state), 32'(ST_IDLE));
            check("mis_after_valid", bus_req_valid, 0);
            return;
        end

        a    = ready_dly + 2;
        tmo  = (rsp_dly < 0) || (rsp_dly >= TMO);
        done = tmo ? a + TMO : a + rsp_dly + 1;
        if (tmo) begin
            m_rdata = NOP_WORD;
            m_tag_v = 1'b0;
        end else if (!wen) begin
            m_rdata = rsp_word;
            m_word  = rsp_word;
            m_tag_a = addr;
            m_tag_v = 1'b1;
        end
        exp_q.push_back(m_rdata);

        for (int c = 1; c <= done + 1; c++) begin
            @(negedge clk);
            inst_sram_en   = 1'b0;
            inst_sram_addr = $urandom;
            bus_req_ready  = (c >= ready_dly + 1);
            bus_rsp_valid  = (rsp_dly >= 0) && ((c == a + rsp_dly) || (tmo && c >= a + rsp_dly));
            bus_rsp_data   = bus_rsp_valid ? rsp_word : $urandom;
            #1;
            exp_st = (c < a) ? ST_REQ : (c < done) ? ST_WAIT : (c == done) ? ST_DONE : ST_IDLE;
            check("bus_state", 32'(dbg_state), 32'(exp_st));
            check("bus_stall", stall_req, 32'(c < done));
            check("bus_valid", bus_req_valid, 32'(c < a));
            if (stall_req) stalls++;
            if (c < a) begin
                check("req_addr", bus_req_addr, addr);
                check("req_wen", bus_req_wen, 32'(wen));
                if (wen) check("req_wdata", bus_req_wdata, wdata);
            end
            if (c == done) begin
                rd = exp_q.pop_front();
                check("done_rdata", inst_sram_read_data, rd);
                check("done_err", fetch_err, 32'(tmo));
            end
            if (c == done + 1) begin
                check("after_rdata", inst_sram_read_data, m_rdata);
                check("after_err", fetch_err, 0);
            end
        end
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          stalls;
        logic [31:0] pool[5];

        rst                  = 1'b0;
        inst_sram_en         = 1'b0;
        inst_sram_wen        = 1'b0;
        inst_sram_addr       = 32'h0;
        inst_sram_write_data = 32'h0;
        bus_req_ready        = 1'b0;
        bus_rsp_valid        = 1'b0;
        bus_rsp_data         = 32'h0;
        model_reset();

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        idle_cycles(2);

        // First fetch: response arrives three cycles after the fetch is presented.
        access(1'b0, 32'h0000_0100, 32'h0, 0, 1, 32'h2402_0005, stalls);
        check("first_fetch_stalls", stalls, 4);

        // Immediate re-read is served from the hit buffer.
        access(1'b0, 32'h0000_0100, 32'h0, 0, 1, 32'hFFFF_FFFF, stalls);
        check("hit_stalls", stalls, 0);

        // Write to the buffered address, then the read must go to the bus.
        access(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1, 0, 32'h0BAD_0BAD, stalls);
        access(1'b0, 32'h0000_0100, 32'h0, 0, 2, 32'h1111_2222, stalls);
        check("reread_after_write_stalls", stalls, 5);

        // Misaligned fetch never reaches the bus.
        access(1'b0, 32'h0000_0102, 32'h0, 0, 0, 32'h0, stalls);

        // No response: timeout, followed by a late response held high.
        access(1'b0, 32'h0000_0200, 32'h0, 0, TMO, 32'h7777_7777, stalls);
        idle_cycles(2);

        // Response in the expiring cycle wins over the timeout.
        access(1'b0, 32'h0000_0300, 32'h0, 0, TMO - 1, 32'hCAFE_F00D, stalls);
        access(1'b0, 32'h0000_0300, 32'h0, 0, 0, 32'h0, stalls);

        // Random traffic over a small address pool so hits and invalidations recur.
        pool[0] = 32'h0000_0100;
        pool[1] = 32'h0000_0104;
        pool[2] = 32'h0000_0108;
        pool[3] = 32'h0000_0101;
        pool[4] = 32'h0000_0106;
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom_range(0, 4) == 0), pool[$urandom_range(0, 4)], $urandom,
                   $urandom_range(0, 2), $urandom_range(0, TMO + 1), $urandom, stalls);
            idle_cycles($urandom_range(0, 2));
        end

        // Reset while waiting for a response, then a stray response after release.
        @(negedge clk);
        inst_sram_en   = 1'b1;
        inst_sram_wen  = 1'b0;
        inst_sram_addr = 32'h0000_0400;
        bus_req_ready  = 1'b1;
        bus_rsp_valid  = 1'b0;
        @(negedge clk);
        inst_sram_en = 1'b0;
        @(negedge clk);
        #1;
        check("rst_pre_state", 32'(dbg_state), 32'(ST_WAIT));
        rst = 1'b0;
        model_reset();
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst           = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rsp_data  = 32'h55AA_55AA;
        #1;
        check_all_zero("rst_rsp");
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        bus_req_ready = 1'b0;
        #1;
        check_all_zero("rst_after");

        // Buffer was cleared by reset: the old address must miss.
        access(1'b0, 32'h0000_0300, 32'h0, 0, 0, 32'h1234_5678, stalls);
        check("post_reset_miss_stalls", stalls, 3);
        idle_cycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_sram_bridge.md
INST_SRAM_BRIDGE -- requirements
Module: inst_sram_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports `clk` and `rst`, with `rst` = 0 meaning reset.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of cycles to wait for a bus response.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-low reset
- inst_sram_en  in  1  CPU fetch enable
- inst_sram_wen  in  1  CPU write enable
- inst_sram_addr  in  32  CPU byte address
- inst_sram_write_data  in  32  CPU write data
- inst_sram_read_data  out  32  fetched word to CPU
- stall_req  out  1  freeze PC and the IF/ID register
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_req_addr  out  32  word-aligned bus address
- bus_req_wen  out  1  bus write
- bus_req_wdata  out  32  bus write data
- bus_rsp_valid  in  1  bus response valid
- bus_rsp_data  in  32  bus response data
- fetch_err  out  1  one-cycle pulse on a misaligned or timed-out access

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT and DONE, encoded as a 2-bit state held in the shared package.
- IDLE->REQ: inst_sram_en=1 and the access is not a hit.
- REQ->WAIT: bus_req_valid & bus_req_ready.
- WAIT->DONE: bus_rsp_valid, or the timeout counter reaches TIMEOUT_CYCLES.
- DONE->IDLE: unconditional.
REQ-005 In state REQ, bus_req_valid SHALL stay 1 until accepted, and bus_req_addr, bus_req_wen and bus_req_wdata SHALL be registered at IDLE exit and held stable.
REQ-006 stall_req SHALL be combinationally 1 in IDLE when a new non-hit access is presented, and 1 throughout REQ and WAIT; it SHALL be 0 in DONE and otherwise.
REQ-007 In WAIT, the response SHALL be captured on the edge where bus_rsp_valid=1, and inst_sram_read_data SHALL show the captured word from DONE onward.
REQ-008 inst_sram_read_data SHALL hold its value until the next capture.
REQ-009 Hit handling:
- A hit is a read (wen=0) whose address equals the last completed read address while the tag is valid.
- A hit SHALL cause no bus traffic and no stall.
- On a hit, the held word SHALL drive read_data on the next cycle, matching the 1-cycle synchronous-SRAM latency.
REQ-010 A write SHALL invalidate the tag whenever the write address matches the tag.
REQ-011 A write SHALL go through REQ/WAIT like a read, and WAIT SHALL end on bus_rsp_valid, with the response data ignored.
REQ-012 A misaligned access (addr[1:0]!=0) SHALL NOT reach the bus.
- The state SHALL go directly to DONE.
- read_data SHALL be 32'h00000000 (NOP).
- fetch_err SHALL pulse for one cycle.
- The tag SHALL NOT be updated.
REQ-013 Timeout handling:
- An 8-bit counter SHALL clear on WAIT entry and increment each WAIT cycle.
- At TIMEOUT_CYCLES, read_data SHALL be 0, fetch_err SHALL pulse, the tag SHALL be invalidated and the state SHALL go to DONE.
- A late bus_rsp_valid SHALL be ignored.
REQ-014 If bus_rsp_valid and the timeout occur in the same cycle, the response data SHALL win and fetch_err SHALL stay 0.
REQ-015 inst_sram_en=0 in IDLE SHALL cause no state change, and read_data SHALL hold.

Reset
REQ-016 While rst=0 the following SHALL hold:
- state = IDLE;
- bus_req_valid, bus_req_wen, stall_req and fetch_err = 0;
- bus_req_addr, bus_req_wdata and read_data = 0;
- tag invalid;
- timeout counter = 0.
REQ-017 Reset asserted mid-transaction SHALL abandon the transaction; bus responses arriving after reset release SHALL be ignored because the state is IDLE.

Structure
REQ-018 The state encoding, the NOP constant (32'h0) and the timeout counter width SHALL live in a shared package with the other pipeline constants.
REQ-019 The timeout counter SHALL be a sub-module named bridge_timer, with ports clear, enable and expired.

Verification
REQ-020 Read 0x100 with bus ready=1 and rsp after 3 cycles of data 0x24020005 -> stall_req high 4 cycles, then read_data=0x24020005, fetch_err=0.
REQ-021 Re-read 0x100 immediately -> no bus_req_valid, stall_req=0, read_data=0x24020005 next cycle.
REQ-022 Write 0x100 with data 0xDEADBEEF, then read 0x100 -> the write reaches the bus, the read misses, and a bus request is issued.
REQ-023 Read 0x102 -> no bus request, read_data=0, fetch_err single-cycle pulse.
REQ-024 Read 0x200 with ready=1 and no rsp, TIMEOUT_CYCLES=4 -> DONE after 4 WAIT cycles, read_data=0, fetch_err=1; a late rsp is ignored.
REQ-025 Assert rst in WAIT, then rsp arrives -> all outputs 0 and state IDLE, with the rsp ignored.
